// File: rtl/fir_sample_feeder.sv
// rtl/fir_sample_feeder.sv - host-to-FIR sample feeder with FIFO, flush tail and result qualification
//
// Purpose: buffers host samples in a small FIFO and issues one registered
// sample per clock to the FIR Sample_in port. On flush it appends FIR_ORDER
// zero samples so the convolution tail drains, then waits PIPE_LAT clocks
// for the FIR pipeline to empty. sample_valid/sample_last are also delayed by
// PIPE_LAT clocks to qualify the FIR output words.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   in_data/in_valid      host sample and its valid
//   in_ready              FIFO has room; transfer on in_valid & in_ready
//   flush_req             single-cycle pulse requesting a zero tail
//   sample_out            registered sample to FIR Sample_in
//   sample_valid          sample_out carries a real or flush sample
//   sample_last           final flush zero (one-clock pulse)
//   result_valid/last     sample_valid/last delayed by PIPE_LAT clocks
//   busy                  FSM is not idle
//   fifo_count            FIFO occupancy
//   gap_count             saturating RUN-underrun counter (FEEDER_GAP_COUNT_EN only)
//
// Build option: define FEEDER_GAP_COUNT_EN to add the gap_count output.

module fir_sample_feeder #(
    parameter int SAMPLE_SIZE = 6,
    parameter int FIR_ORDER   = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int FIFO_AW     = 3,
    parameter int PIPE_LAT    = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [SAMPLE_SIZE-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   flush_req,
    output logic [SAMPLE_SIZE-1:0] sample_out,
    output logic                   sample_valid,
    output logic                   sample_last,
    output logic                   result_valid,
    output logic                   result_last,
    output logic                   busy,
    output logic [FIFO_AW:0]       fifo_count
`ifdef FEEDER_GAP_COUNT_EN
    ,
    output logic [15:0]            gap_count
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam int ZW = $clog2(FIR_ORDER + 1);
    localparam int DW = $clog2(PIPE_LAT + 1);

    logic [SAMPLE_SIZE-1:0] mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]     wr_ptr;
    logic [FIFO_AW-1:0]     rd_ptr;
    logic [1:0]             state;
    logic                   flush_pending;
    logic [ZW-1:0]          zcnt;
    logic [DW-1:0]          dcnt;
    logic [PIPE_LAT-1:0]    valid_pipe;
    logic [PIPE_LAT-1:0]    last_pipe;

    logic fifo_empty;
    logic push;
    logic pop;
    logic underrun;
    logic start_flush;

    assign fifo_empty  = (fifo_count == '0);
    assign in_ready    = (fifo_count < (FIFO_AW+1)'(FIFO_DEPTH));
    assign push        = in_valid && in_ready;
    assign pop         = !fifo_empty && (state == ST_IDLE || state == ST_RUN);
    assign underrun    = (state == ST_RUN) && fifo_empty && !flush_pending;
    assign start_flush = (state == ST_RUN) && fifo_empty && flush_pending;
    assign busy        = (state != ST_IDLE);
    assign result_valid = valid_pipe[PIPE_LAT-1];
    assign result_last  = last_pipe[PIPE_LAT-1];

    // FIFO storage needs no reset: entries are only read after being written.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers are FIFO_AW bits wide, so they wrap modulo FIFO_DEPTH for free.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // A request only counts while real samples are still in flight; once the
    // tail has started, further requests would double the zero padding.
    always_ff @(posedge clock) begin
        if (reset) begin
            flush_pending <= 1'b0;
        end else if (start_flush) begin
            flush_pending <= 1'b0;
        end else if (flush_req && (state == ST_RUN || (state == ST_IDLE && !fifo_empty))) begin
            flush_pending <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            sample_last  <= 1'b0;
            zcnt         <= '0;
            dcnt         <= '0;
        end else begin
            sample_last <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        sample_out   <= mem[rd_ptr];
                        sample_valid <= 1'b1;
                        state        <= ST_RUN;
                    end else begin
                        sample_out   <= '0;
                        sample_valid <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (pop) begin
                        sample_out   <= mem[rd_ptr];
                        sample_valid <= 1'b1;
                    end else if (start_flush) begin
                        // First tail zero goes out on this edge.
                        sample_out   <= '0;
                        sample_valid <= 1'b1;
                        zcnt         <= ZW'(FIR_ORDER - 1);
                        state        <= ST_FLUSH;
                    end else begin
                        sample_out   <= '0;
                        sample_valid <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    sample_out   <= '0;
                    sample_valid <= 1'b1;
                    zcnt         <= zcnt - 1'b1;
                    // zcnt==1 here means this edge emits the final zero.
                    if (zcnt == ZW'(1)) begin
                        sample_last <= 1'b1;
                        dcnt        <= DW'(PIPE_LAT - 1);
                        state       <= ST_DRAIN;
                    end
                end
                default: begin
                    sample_out   <= '0;
                    sample_valid <= 1'b0;
                    if (dcnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        dcnt <= dcnt - 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_pipe <= '0;
            last_pipe  <= '0;
        end else begin
            valid_pipe[0] <= sample_valid;
            last_pipe[0]  <= sample_last;
            for (int i = 1; i < PIPE_LAT; i++) begin
                valid_pipe[i] <= valid_pipe[i-1];
                last_pipe[i]  <= last_pipe[i-1];
            end
        end
    end

`ifdef FEEDER_GAP_COUNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            gap_count <= '0;
        end else if (underrun && gap_count != 16'hFFFF) begin
            gap_count <= gap_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fir_sample_feeder.sv
// tb/tb_fir_sample_feeder.sv - directed self-checking bench for fir_sample_feeder

module tb_fir_sample_feeder;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       flush_req;
    logic [5:0] sample_out;
    logic       sample_valid;
    logic       sample_last;
    logic       result_valid;
    logic       result_last;
    logic       busy;
    logic [3:0] fifo_count;
`ifdef FEEDER_GAP_COUNT_EN
    logic [15:0] gap_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    fir_sample_feeder dut (
        .clock        (clock),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .flush_req    (flush_req),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_last  (sample_last),
        .result_valid (result_valid),
        .result_last  (result_last),
        .busy         (busy),
        .fifo_count   (fifo_count)
`ifdef FEEDER_GAP_COUNT_EN
        ,
        .gap_count    (gap_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Inputs are changed 1 time unit after an edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] d, input logic f);
        in_valid  = v;
        in_data   = d;
        flush_req = f;
    endtask

    // Expected per-edge trace for the 10,20,30 + flush scenario.
    int e_out  [13] = '{0, 10, 20, 30, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int e_v    [13] = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    int e_l    [13] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    int e_rv   [13] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    int e_rl   [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    int e_busy [13] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};

    initial begin
        // ---- reset held 2 clocks with in_valid asserted ----
        reset = 1'b1;
        drive(1'b1, 6'd3, 1'b0);
        tick();
        tick();
        chk("rst_sample_out", 32'(sample_out), 0);
        chk("rst_sample_valid", 32'(sample_valid), 0);
        chk("rst_sample_last", 32'(sample_last), 0);
        chk("rst_result_valid", 32'(result_valid), 0);
        chk("rst_result_last", 32'(result_last), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fifo_count", 32'(fifo_count), 0);
        reset = 1'b0;
        drive(1'b0, 6'd0, 1'b0);
        tick();
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_count_after", 32'(fifo_count), 0);

        // ---- push 10,20,30 with flush on 30 ----
        for (int k = 0; k < 13; k++) begin
            case (k)
                0:       drive(1'b1, 6'd10, 1'b0);
                1:       drive(1'b1, 6'd20, 1'b0);
                2:       drive(1'b1, 6'd30, 1'b1);
                default: drive(1'b0, 6'd0, 1'b0);
            endcase
            tick();
            chk($sformatf("fl_out[%0d]", k), 32'(sample_out), 32'(e_out[k]));
            chk($sformatf("fl_valid[%0d]", k), 32'(sample_valid), 32'(e_v[k]));
            chk($sformatf("fl_last[%0d]", k), 32'(sample_last), 32'(e_l[k]));
            chk($sformatf("fl_rvalid[%0d]", k), 32'(result_valid), 32'(e_rv[k]));
            chk($sformatf("fl_rlast[%0d]", k), 32'(result_last), 32'(e_rl[k]));
            chk($sformatf("fl_busy[%0d]", k), 32'(busy), 32'(e_busy[k]));
        end
        tick();
        chk("fl_rvalid_end", 32'(result_valid), 0);
        chk("fl_rlast_end", 32'(result_last), 0);

        // ---- underrun: push 5, 2 idle clocks, push 7 ----
        drive(1'b1, 6'd5, 1'b0);
        tick();
        drive(1'b0, 6'd0, 1'b0);
        tick();
        chk("ur_out0", 32'(sample_out), 5);
        chk("ur_v0", 32'(sample_valid), 1);
        tick();
        chk("ur_out1", 32'(sample_out), 0);
        chk("ur_v1", 32'(sample_valid), 0);
        chk("ur_busy1", 32'(busy), 1);
        drive(1'b1, 6'd7, 1'b0);
        tick();
        chk("ur_out2", 32'(sample_out), 0);
        chk("ur_v2", 32'(sample_valid), 0);
        chk("ur_busy2", 32'(busy), 1);
        drive(1'b0, 6'd0, 1'b0);
        tick();
        chk("ur_out3", 32'(sample_out), 7);
        chk("ur_v3", 32'(sample_valid), 1);
`ifdef FEEDER_GAP_COUNT_EN
        chk("ur_gap_count", 32'(gap_count), 2);
`endif

        // ---- backpressure: flush from RUN, push 8 during FLUSH/DRAIN ----
        drive(1'b0, 6'd0, 1'b1);
        tick();
        chk("bp_pre_v", 32'(sample_valid), 0);
        drive(1'b0, 6'd0, 1'b0);
        tick();
        chk("bp_zero1_v", 32'(sample_valid), 1);
        chk("bp_zero1_busy", 32'(busy), 1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 6'(41 + i), 1'b0);
            tick();
            chk($sformatf("bp_count[%0d]", i), 32'(fifo_count), 32'(i + 1));
            if (i == 2) chk("bp_last_zero", 32'(sample_last), 1);
            if (i == 6) chk("bp_ready_at7", 32'(in_ready), 1);
        end
        chk("bp_ready_full", 32'(in_ready), 0);
        chk("bp_idle", 32'(busy), 0);
        drive(1'b1, 6'd49, 1'b0);
        tick();
        chk("bp_held_count", 32'(fifo_count), 7);
        chk("bp_out0", 32'(sample_out), 41);
        drive(1'b0, 6'd0, 1'b0);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("bp_out[%0d]", i), 32'(sample_out), 32'(41 + i));
            chk($sformatf("bp_v[%0d]", i), 32'(sample_valid), 1);
        end
        chk("bp_empty", 32'(fifo_count), 0);

        // ---- reset in the middle of FLUSH ----
        drive(1'b0, 6'd0, 1'b1);
        tick();
        drive(1'b0, 6'd0, 1'b0);
        tick();
        tick();
        chk("mr_flush_v", 32'(sample_valid), 1);
        chk("mr_flush_busy", 32'(busy), 1);
        reset = 1'b1;
        tick();
        chk("mr_out", 32'(sample_out), 0);
        chk("mr_v", 32'(sample_valid), 0);
        chk("mr_l", 32'(sample_last), 0);
        chk("mr_rv", 32'(result_valid), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_count", 32'(fifo_count), 0);
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("mr_rv_after[%0d]", i), 32'(result_valid), 0);
            chk($sformatf("mr_v_after[%0d]", i), 32'(sample_valid), 0);
        end

`ifdef FEEDER_GAP_COUNT_EN
        // ---- gap counter saturation ----
        chk("gc_reset", 32'(gap_count), 0);
        drive(1'b1, 6'd1, 1'b0);
        tick();
        drive(1'b0, 6'd0, 1'b0);
        tick();
        for (int i = 0; i < 65540; i++) tick();
        chk("gc_saturate", 32'(gap_count), 65535);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
